morse_units_to_signal: RTL
==========================

# morse_units_to_signal

Transmit-side Morse keyer and the counterpart of the receive-side pulse-to-unit measurement. It accepts one Morse element per handshake (dot, dash, letter gap, word gap) and drives the keyed `signal` line. Each element is timed in units, and each unit is `pulses_per_unit` clock-enable pulses long. It sits between the character-to-element sequencer and the output/loopback path.

## Interface
Parameters:
- `UNIT_BCD_W`, default 6 (from `defines.vh`): number of BCD digits in `pulses_per_unit`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  reset, asynchronous, active-high.
- `ce`  in  1  timing enable; one pulse is one timebase tick.
- `pulses_per_unit`  in  `UNIT_BCD_W*4`  unit length in ce pulses, packed BCD.
- `sym_valid`  in  1  element request.
- `sym_code`  in  2  element: 0=DOT, 1=DASH, 2=LETTER_GAP, 3=WORD_GAP.
- `sym_ready`  out  1  keyer can accept an element.
- `signal`  out  1  keyed output; 1 = tone/mark.
- `busy`  out  1  element in progress (`~sym_ready`).

## Operation
- Reset values while `clr` is high: `signal`=0, `sym_ready`=1, `busy`=0, state IDLE, all counters 0.
- Element timing, as (mark units, space units):
  - DOT = (1,1)
  - DASH = (3,1)
  - LETTER_GAP = (0,2). After a preceding element's 1-unit space, this gives 3 units total.
  - WORD_GAP = (0,6). This gives 7 units total.
- The state machine has three states: IDLE, MARK, SPACE.
  - IDLE: `sym_ready`=1. A transfer happens on any clk edge with `sym_valid & sym_ready`, regardless of `ce`.
    - On that edge the block latches `pulses_per_unit` and the unit targets, and clears the counters.
    - If the mark target is nonzero, it goes to MARK and sets `signal`=1. Otherwise it goes to SPACE.
    - `sym_ready` drops on the same edge.
  - MARK: each `ce` increments the BCD pulse counter. When the counter equals the latched ppu-1 and `ce`=1, the pulse counter wraps to 0 and the unit counter increments. When that completes the mark target, the block goes to SPACE and sets `signal`=0 on that edge.
  - SPACE: counting is identical. When the space target completes, the block goes to IDLE and sets `sym_ready`=1 on that edge.
- `pulses_per_unit` is sampled only at the transfer. Changes mid-element have no effect.
- A `pulses_per_unit` value of 0, or one containing any digit >9, is latched as 1.
- The unit counter is 3-bit binary (max 6). The pulse counter is `UNIT_BCD_W`-digit BCD with a synchronous clear.
- `sym_valid` held high in IDLE is consumed on the first edge. Requests seen while busy are ignored, with no queueing. The sender must hold `sym_valid` and `sym_code` until it sees `sym_ready`.
- `clr` asserted mid-element: `signal` drops asynchronously to 0 immediately, the element is discarded, and the block returns to IDLE.

## Timing
- Latency from transfer edge to `signal` high: 0 edges. `signal` is registered and visible after the transfer edge.
- Mark duration is exactly mark_units × ppu `ce` pulses after the transfer edge. Space duration is exactly space_units × ppu `ce` pulses after that.
- With `ce` held at 1: back-to-back elements need one IDLE cycle between them (ready edge, then transfer edge). The gap is therefore space × ppu + 1 clk.
- With `ce` held at 0: the block freezes in its current state and `signal` holds. Handshake acceptance is still possible in IDLE.
- `busy` and `sym_ready` are never both high.

## Structure
- Add to shared `defines.vh`:
  - element code constants `SYM_DOT`, `SYM_DASH`, `SYM_LGAP`, `SYM_WGAP`
  - unit constants `UNITS_DOT`=1, `UNITS_DASH`=3, `UNITS_ESPACE`=1, `UNITS_LGAP`=2, `UNITS_WGAP`=6
  - existing `UNIT_BCD_W`
- One sub-module, `bcd_unit_timer`: BCD pulse counter with ce, synchronous clear, a terminal-compare against the latched ppu, and a one-cycle `unit_tick` output. The top holds the FSM and the unit counter.

## Test plan
- DOT with ppu=2, `ce`=1 constant → `signal` high for 2 clk; low for 2 clk; `sym_ready` returns 4 clk after the transfer edge.
- DASH with ppu=3, `ce` pulsed every 4th clk → `signal` high for exactly 9 `ce` pulses (36 clk); space of 3 `ce` pulses.
- WORD_GAP with ppu=5 → `signal` stays 0; `busy` lasts 30 `ce` pulses; a DOT queued immediately after starts on the first IDLE edge.
- ppu=0, then ppu=0x00000A → both time as ppu=1; a DOT gives a 1-`ce` mark and a 1-`ce` space.
- Change ppu from 2 to 9 mid-DASH, and toggle `sym_valid` while busy → timing stays at ppu=2; the extra requests are ignored.
- `clr` pulsed mid-MARK → `signal`=0 immediately (before the next clk edge), `sym_ready`=1, and the next DOT is timed from fresh.

Source files
------------

// File: rtl/morse_units_to_signal_pkg.sv
// Shared element codes, unit counts and FSM types for the Morse keyer.
package morse_units_to_signal_pkg;

  typedef enum logic [1:0] {
    SYM_DOT  = 2'd0,
    SYM_DASH = 2'd1,
    SYM_LGAP = 2'd2,
    SYM_WGAP = 2'd3
  } sym_e;

  localparam logic [2:0] UNITS_DOT    = 3'd1;
  localparam logic [2:0] UNITS_DASH   = 3'd3;
  localparam logic [2:0] UNITS_ESPACE = 3'd1;
  localparam logic [2:0] UNITS_LGAP   = 3'd2;
  localparam logic [2:0] UNITS_WGAP   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } state_e;

  typedef struct packed {
    logic [2:0] mark;
    logic [2:0] space;
  } units_t;

  // Gaps carry no trailing element space; the preceding element supplies it.
  function automatic units_t sym_units(input logic [1:0] code);
    units_t u;
    case (code)
      SYM_DOT:  u = '{mark: UNITS_DOT,  space: UNITS_ESPACE};
      SYM_DASH: u = '{mark: UNITS_DASH, space: UNITS_ESPACE};
      SYM_LGAP: u = '{mark: 3'd0,       space: UNITS_LGAP};
      default:  u = '{mark: 3'd0,       space: UNITS_WGAP};
    endcase
    return u;
  endfunction

endpackage

// File: rtl/morse_units_to_signal_bcd_unit_timer.sv
// BCD pulse counter that emits a one-cycle unit_tick every ppu enabled ce pulses.
module bcd_unit_timer #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  ce,
  input  logic                  en,
  input  logic                  sclr,
  input  logic [DIGITS*4-1:0]   ppu,
  output logic                  unit_tick
);

  logic [DIGITS*4-1:0] cnt_q;
  logic [DIGITS*4-1:0] cnt_inc;

  always_comb begin : bcd_inc
    logic       carry;
    logic [3:0] d;
    carry   = 1'b1;
    cnt_inc = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = cnt_q[i*4 +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          cnt_inc[i*4 +: 4] = 4'd0;
        end else begin
          cnt_inc[i*4 +: 4] = d + 4'd1;
          carry             = 1'b0;
        end
      end else begin
        cnt_inc[i*4 +: 4] = d;
      end
    end
  end

  // Comparing the incremented count against ppu is the same as cnt == ppu-1.
  assign unit_tick = en & ce & (cnt_inc == ppu);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)            cnt_q <= '0;
    else if (sclr)      cnt_q <= '0;
    else if (en && ce)  cnt_q <= unit_tick ? '0 : cnt_inc;
  end

endmodule

// File: rtl/morse_units_to_signal.sv
// Morse keyer: one element per handshake, keyed output timed in ppu-pulse units.
module morse_units_to_signal
  import morse_units_to_signal_pkg::*;
#(
  parameter int UNIT_BCD_W = 6
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    ce,
  input  logic [UNIT_BCD_W*4-1:0] pulses_per_unit,
  input  logic                    sym_valid,
  input  logic [1:0]              sym_code,
  output logic                    sym_ready,
  output logic                    signal,
  output logic                    busy
);

  localparam int PW = UNIT_BCD_W * 4;

  state_e          state_q, state_d;
  logic            signal_d;
  logic [PW-1:0]   ppu_q, ppu_clean;
  units_t          tgt_q, req_units;
  logic [2:0]      unit_q, unit_d, unit_inc;
  logic            take, unit_tick;

  assign sym_ready = (state_q == ST_IDLE);
  assign busy      = ~sym_ready;
  assign take      = sym_valid & sym_ready;
  assign req_units = sym_units(sym_code);
  assign unit_inc  = unit_q + 3'd1;

  // Zero or non-decimal unit lengths fall back to a single pulse per unit.
  always_comb begin : sanitize
    logic bad;
    bad = (pulses_per_unit == '0);
    for (int i = 0; i < UNIT_BCD_W; i++)
      if (pulses_per_unit[i*4 +: 4] > 4'd9) bad = 1'b1;
    ppu_clean = bad ? PW'(1) : pulses_per_unit;
  end

  always_comb begin
    state_d  = state_q;
    signal_d = signal;
    unit_d   = unit_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          unit_d = 3'd0;
          if (req_units.mark != 3'd0) begin
            state_d  = ST_MARK;
            signal_d = 1'b1;
          end else begin
            state_d  = ST_SPACE;
          end
        end
      end
      ST_MARK: begin
        if (unit_tick) begin
          if (unit_inc == tgt_q.mark) begin
            state_d  = ST_SPACE;
            signal_d = 1'b0;
            unit_d   = 3'd0;
          end else begin
            unit_d   = unit_inc;
          end
        end
      end
      ST_SPACE: begin
        if (unit_tick) begin
          if (unit_inc == tgt_q.space) begin
            state_d = ST_IDLE;
            unit_d  = 3'd0;
          end else begin
            unit_d  = unit_inc;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        signal_d = 1'b0;
        unit_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      signal  <= 1'b0;
      unit_q  <= 3'd0;
      ppu_q   <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      signal  <= signal_d;
      unit_q  <= unit_d;
      if (take) begin
        ppu_q <= ppu_clean;
        tgt_q <= req_units;
      end
    end
  end

  bcd_unit_timer #(.DIGITS(UNIT_BCD_W)) u_timer (
    .clk       (clk),
    .clr       (clr),
    .ce        (ce),
    .en        (state_q != ST_IDLE),
    .sclr      (take),
    .ppu       (ppu_q),
    .unit_tick (unit_tick)
  );

endmodule
